multicycle_ctrl_fsm: RTL
========================

# multicycle_ctrl_fsm

Parametrised successor to the multicycle control unit: a Moore-style FSM (Mealy only on memory-ready gating) that sequences fetch/decode/execute for the 16-bit datapath. Adds a memory-ready handshake with a bus-timeout counter, precise exception entry with cause codes, an illegal-opcode trap, return-from-exception, and an optional maskable external interrupt. Sits between the instruction register opcode field and all datapath mux/enable controls.

## Interface
- OPW, 4: opcode width; must be ≥4, opcodes ≥16 are illegal.
- CAUSE_W, 2: IntCause width; must be ≥2.
- MEM_TIMEOUT, 15: maximum wait cycles per memory state before bus-error trap; ≥1.
- CLK  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Opcode  in  OPW  IR opcode field, valid from DECODE onward.
- MemReady  in  1  memory completes the access this cycle.
- IntReq  in  1  level external interrupt request.
- PCSrc  out  3  0 ALU, 1 ALUOut (branch), 2 register, 3 jump target, 4 trap vector, 5 EPC.
- PCWrite, isBranch, IorD, MemRead, MemWrite, IRWrite, CRWrite, RegWrite, ALUSrcA  out  1 each.
- WriteDest  out  2; WriteSrc  out  3; ALUSrcB  out  3; ALUOp  out  2.
- IntCause  out  CAUSE_W; CauseWrite, EPCWrite, IntAck  out  1 each.
- IntEnable  out  1  current interrupt-enable flag.
- current_state, next_state  out  5  debug.

## Operation
- Every output is assigned in every state; any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=1, ALUSrcA=1, ALUSrcB=1, ALUOp=0, PCSrc=0, IRWrite=PCWrite=MemReady. Stay until MemReady.
- DECODE: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Opcode dispatch: 0 C_EXEC, 1/2 BRANCH, 3 JUMP, 4 JAL1, 5 JREG, 6 LUI, 7 LLI, 8 LTR, 9 CTR, 10 LW1, 11 SW, 12 SYSCALL, 13 TRAP (cause 0), 14 RFE, else TRAP (cause 1).
- C_EXEC: ALUSrcB=0, ALUOp=2 → C_WRITE: WriteDest=1, CRWrite=1, RegWrite=1, WriteSrc=0.
- BRANCH: ALUSrcB=4, ALUOp=1, isBranch=1, PCSrc=1. JUMP: PCWrite=1, PCSrc=3.
- JAL1: RegWrite=1, WriteDest=2, WriteSrc=5 → JAL2: PCWrite=1, PCSrc=3. JREG: PCWrite=1, PCSrc=2.
- LUI/LLI/CTR/LTR: RegWrite=1, WriteDest=0, WriteSrc=3/4/1/6 respectively.
- LW1: MemRead=1, IorD=0; stay until MemReady → LW2: RegWrite=1, WriteDest=0, WriteSrc=2. SW: MemWrite=1, IorD=0; stay until MemReady.
- SYSCALL: ALUSrcA=1, ALUSrcB=1, ALUOp=0, PCWrite=1, PCSrc=0.
- TRAP: EPCWrite=1, CauseWrite=1, IntCause=latched cause, PCWrite=1, PCSrc=4; clears IntEnable.
- RFE: PCWrite=1, PCSrc=5; sets IntEnable.
- IRQ: as TRAP with IntCause=2, plus IntAck=1.
- Bus timeout: 4-bit-or-wider wait counter clears on entry to FETCH/LW1/SW and counts each cycle MemReady=0; when count reaches MEM_TIMEOUT with MemReady=0 → TRAP, cause 3. MemReady on the same cycle wins.
- All other terminal states (C_WRITE, BRANCH, JUMP, JAL2, JREG, LUI, LLI, LTR, CTR, LW2, SW done, SYSCALL, TRAP, RFE, IRQ) return to FETCH, subject to IRQ check below.

## Timing
- Reset: state FETCH, cause register 0, wait counter 0, IntEnable=1; outputs take FETCH values immediately (MemRead=1, IorD=1, ALUSrcA=1, ALUSrcB=1).
- Reset_n asserted mid-instruction aborts immediately; no partial writes after the edge.
- Zero-wait latencies: R-type 4 cycles, LW 4, SW 3, branch/jump/LUI/LLI/CTR/LTR/JREG/SYSCALL 3, JAL 4, trap/RFE 3; each memory wait adds 1.
- Cause latched on the DECODE or wait-state edge that selects TRAP.
- IRQ check on the transition that would enter FETCH: if IntReq && IntEnable → IRQ instead (adds 1 cycle). Never checked while leaving TRAP/IRQ (IntEnable already 0 then) or RFE (IRQ taken only after next instruction).
- Trap from DECODE and pending IntReq in same cycle: TRAP first; IRQ remains masked until RFE.

## Configuration
- CTRL_IRQ_EN defined: IntReq/IRQ state/IntAck functional as above.
- Undefined: IRQ state absent, IntReq ignored, IntAck constant 0; IntEnable still tracks TRAP/RFE.

## Test plan
- Reset_n low then high, MemReady=1, opcode 0 → states 0,1,C_EXEC,C_WRITE,FETCH; RegWrite=1 only in C_WRITE, WriteDest=1.
- Opcode 10 with MemReady low 3 cycles in LW1 → LW1 held 4 cycles, then LW2 with WriteSrc=2; total 7 cycles.
- MemReady held 0 in FETCH → after 15 wait cycles TRAP with CauseWrite=1, IntCause=3, PCSrc=4.
- Opcode 15 → TRAP IntCause=1, EPCWrite=1, IntEnable→0; then opcode 14 → RFE PCSrc=5, IntEnable→1.
- CTRL_IRQ_EN, IntReq=1 during opcode 6 → LUI, IRQ (IntAck=1, IntCause=2), FETCH; IntReq held → no second IRQ until RFE.
- Reset_n pulsed low during SW wait → outputs instantly FETCH values, MemWrite=0, IntEnable=1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// multicycle_ctrl_fsm: fetch/decode/execute sequencer for the 16-bit multicycle datapath.
// Optional maskable external interrupt enabled by defining CTRL_IRQ_EN.
module multicycle_ctrl_fsm #(
  parameter int OPW         = 4,
  parameter int CAUSE_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [OPW-1:0]     opcode_i,
  input  logic               mem_ready_i,
  input  logic               int_req_i,
  output logic [2:0]         pc_src_o,
  output logic               pc_write_o,
  output logic               is_branch_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               cr_write_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         write_dest_o,
  output logic [2:0]         write_src_o,
  output logic [2:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic [CAUSE_W-1:0] int_cause_o,
  output logic               cause_write_o,
  output logic               epc_write_o,
  output logic               int_ack_o,
  output logic               int_enable_o,
  output logic [4:0]         current_state_o,
  output logic [4:0]         next_state_o
);

  localparam int CNT_W_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int CNT_W     = (CNT_W_RAW > 4) ? CNT_W_RAW : 4;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,  S_DECODE = 5'd1,  S_C_EXEC = 5'd2,  S_C_WRITE = 5'd3,
    S_BRANCH  = 5'd4,  S_JUMP   = 5'd5,  S_JAL1   = 5'd6,  S_JAL2    = 5'd7,
    S_JREG    = 5'd8,  S_LUI    = 5'd9,  S_LLI    = 5'd10, S_LTR     = 5'd11,
    S_CTR     = 5'd12, S_LW1    = 5'd13, S_LW2    = 5'd14, S_SW      = 5'd15,
`ifdef CTRL_IRQ_EN
    S_IRQ     = 5'd19,
`endif
    S_SYSCALL = 5'd16, S_TRAP   = 5'd17, S_RFE    = 5'd18
  } state_t;

  typedef struct packed {
    logic [2:0]         pc_src;
    logic               pc_write;
    logic               is_branch;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               cr_write;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         write_dest;
    logic [2:0]         write_src;
    logic [2:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [CAUSE_W-1:0] int_cause;
    logic               cause_write;
    logic               epc_write;
    logic               int_ack;
  } ctrl_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               int_en_q, int_en_d;
  ctrl_t              ctrl_q;
  logic               go_fetch, timed_out, in_wait, entering_wait;

  // Controls are registered from the next state so they line up with state_q.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [CAUSE_W-1:0] cause);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.iord = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 3'd1; end
      S_DECODE:  begin c.alu_src_a = 1'b1; c.alu_src_b = 3'd2; end
      S_C_EXEC:  c.alu_op = 2'd2;
      S_C_WRITE: begin c.write_dest = 2'd1; c.cr_write = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:  begin c.alu_src_b = 3'd4; c.alu_op = 2'd1; c.is_branch = 1'b1; c.pc_src = 3'd1; end
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_src = 3'd3; end
      S_JAL1:    begin c.reg_write = 1'b1; c.write_dest = 2'd2; c.write_src = 3'd5; end
      S_JAL2:    begin c.pc_write = 1'b1; c.pc_src = 3'd3; end
      S_JREG:    begin c.pc_write = 1'b1; c.pc_src = 3'd2; end
      S_LUI:     begin c.reg_write = 1'b1; c.write_src = 3'd3; end
      S_LLI:     begin c.reg_write = 1'b1; c.write_src = 3'd4; end
      S_LTR:     begin c.reg_write = 1'b1; c.write_src = 3'd6; end
      S_CTR:     begin c.reg_write = 1'b1; c.write_src = 3'd1; end
      S_LW1:     c.mem_read = 1'b1;
      S_LW2:     begin c.reg_write = 1'b1; c.write_src = 3'd2; end
      S_SW:      c.mem_write = 1'b1;
      S_SYSCALL: begin c.alu_src_a = 1'b1; c.alu_src_b = 3'd1; c.pc_write = 1'b1; end
      S_TRAP: begin
        c.epc_write = 1'b1; c.cause_write = 1'b1; c.int_cause = cause;
        c.pc_write  = 1'b1; c.pc_src = 3'd4;
      end
      S_RFE:     begin c.pc_write = 1'b1; c.pc_src = 3'd5; end
`ifdef CTRL_IRQ_EN
      S_IRQ: begin
        c.epc_write = 1'b1; c.cause_write = 1'b1; c.int_cause = CAUSE_W'(2);
        c.pc_write  = 1'b1; c.pc_src = 3'd4; c.int_ack = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    go_fetch  = 1'b0;
    timed_out = (wait_q == CNT_W'(MEM_TIMEOUT)) && !mem_ready_i;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i)    state_d = S_DECODE;
        else if (timed_out) begin state_d = S_TRAP; cause_d = CAUSE_W'(3); end
      end
      S_DECODE: begin
        case (opcode_i)
          OPW'(0):  state_d = S_C_EXEC;
          OPW'(1):  state_d = S_BRANCH;
          OPW'(2):  state_d = S_BRANCH;
          OPW'(3):  state_d = S_JUMP;
          OPW'(4):  state_d = S_JAL1;
          OPW'(5):  state_d = S_JREG;
          OPW'(6):  state_d = S_LUI;
          OPW'(7):  state_d = S_LLI;
          OPW'(8):  state_d = S_LTR;
          OPW'(9):  state_d = S_CTR;
          OPW'(10): state_d = S_LW1;
          OPW'(11): state_d = S_SW;
          OPW'(12): state_d = S_SYSCALL;
          OPW'(13): begin state_d = S_TRAP; cause_d = CAUSE_W'(0); end
          OPW'(14): state_d = S_RFE;
          default:  begin state_d = S_TRAP; cause_d = CAUSE_W'(1); end
        endcase
      end
      S_C_EXEC: state_d = S_C_WRITE;
      S_JAL1:   state_d = S_JAL2;
      S_LW1: begin
        if (mem_ready_i)    state_d = S_LW2;
        else if (timed_out) begin state_d = S_TRAP; cause_d = CAUSE_W'(3); end
      end
      S_SW: begin
        if (mem_ready_i)    go_fetch = 1'b1;
        else if (timed_out) begin state_d = S_TRAP; cause_d = CAUSE_W'(3); end
      end
      // Exception entry/exit never takes the interrupt on its way back to fetch.
`ifdef CTRL_IRQ_EN
      S_IRQ:    state_d = S_FETCH;
`endif
      S_TRAP:   state_d = S_FETCH;
      S_RFE:    state_d = S_FETCH;
      default:  go_fetch = 1'b1;
    endcase
    if (go_fetch) begin
      state_d = S_FETCH;
`ifdef CTRL_IRQ_EN
      if (int_req_i && int_en_q) state_d = S_IRQ;
`endif
    end
  end

`ifndef CTRL_IRQ_EN
  logic unused_int_req;
  assign unused_int_req = int_req_i;
`endif

  always_comb begin
    int_en_d = int_en_q;
    if (state_d == S_TRAP) int_en_d = 1'b0;
`ifdef CTRL_IRQ_EN
    if (state_d == S_IRQ)  int_en_d = 1'b0;
`endif
    if (state_d == S_RFE)  int_en_d = 1'b1;
  end

  assign in_wait       = (state_q == S_FETCH) || (state_q == S_LW1) || (state_q == S_SW);
  assign entering_wait = (state_d != state_q) &&
                         ((state_d == S_FETCH) || (state_d == S_LW1) || (state_d == S_SW));

  always_comb begin
    wait_d = wait_q;
    if (entering_wait)                wait_d = '0;
    else if (in_wait && !mem_ready_i) wait_d = wait_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_FETCH;
      wait_q   <= '0;
      cause_q  <= '0;
      int_en_q <= 1'b1;
      ctrl_q   <= decode_ctrl(S_FETCH, '0);
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cause_q  <= cause_d;
      int_en_q <= int_en_d;
      ctrl_q   <= decode_ctrl(state_d, cause_d);
    end
  end

  // Instruction fetch commits IR and PC only in the cycle memory responds.
  assign ir_write_o      = (state_q == S_FETCH) && mem_ready_i;
  assign pc_write_o      = ctrl_q.pc_write | ir_write_o;
  assign pc_src_o        = ctrl_q.pc_src;
  assign is_branch_o     = ctrl_q.is_branch;
  assign iord_o          = ctrl_q.iord;
  assign mem_read_o      = ctrl_q.mem_read;
  assign mem_write_o     = ctrl_q.mem_write;
  assign cr_write_o      = ctrl_q.cr_write;
  assign reg_write_o     = ctrl_q.reg_write;
  assign alu_src_a_o     = ctrl_q.alu_src_a;
  assign write_dest_o    = ctrl_q.write_dest;
  assign write_src_o     = ctrl_q.write_src;
  assign alu_src_b_o     = ctrl_q.alu_src_b;
  assign alu_op_o        = ctrl_q.alu_op;
  assign int_cause_o     = ctrl_q.int_cause;
  assign cause_write_o   = ctrl_q.cause_write;
  assign epc_write_o     = ctrl_q.epc_write;
  assign int_ack_o       = ctrl_q.int_ack;
  assign int_enable_o    = int_en_q;
  assign current_state_o = state_q;
  assign next_state_o    = state_d;

endmodule
`default_nettype wire
